// File: rtl/spi_master_multimode_if.sv
// Command/response bundle between the CSR/GPIO layer (master) and the SPI engine (slave).
interface spi_master_multimode_if #(
    parameter int CSB_WIDTH = 9,
    parameter int MAX_BITS  = 32
);
    localparam int DEVSEL_WIDTH = (CSB_WIDTH > 1) ? $clog2(CSB_WIDTH) : 1;
    localparam int LEN_WIDTH    = $clog2(MAX_BITS + 1);

    logic                    cmdValid;
    logic                    cmdReady;
    logic [MAX_BITS-1:0]     cmdData;
    logic [LEN_WIDTH-1:0]    cmdLength;
    logic [DEVSEL_WIDTH-1:0] cmdDevSel;
    logic                    cmdCPOL;
    logic                    cmdCPHA;
    logic                    cmdLSBFirst;
    logic                    rspValid;
    logic [MAX_BITS-1:0]     rspData;
    logic                    busy;

    modport master (
        output cmdValid, cmdData, cmdLength, cmdDevSel, cmdCPOL, cmdCPHA, cmdLSBFirst,
        input  cmdReady, rspValid, rspData, busy
    );
    modport slave (
        input  cmdValid, cmdData, cmdLength, cmdDevSel, cmdCPOL, cmdCPHA, cmdLSBFirst,
        output cmdReady, rspValid, rspData, busy
    );
endinterface

// File: rtl/spi_master_multimode.sv
// Multi-mode SPI master: variable length, CPOL/CPHA, MSB/LSB-first, per-command chip select.
// Optional latch-enable outputs are built when SPI_MASTER_LE_EN is defined.
module spi_master_multimode #(
    parameter int CLK_RATE  = 100000000,
    parameter int BIT_RATE  = 12500000,
    parameter int CSB_WIDTH = 9,
    parameter int MAX_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_master_multimode_if.slave cmd,
    output logic                  SPI_CLK,
    output logic [CSB_WIDTH-1:0]  SPI_CSB,
`ifdef SPI_MASTER_LE_EN
    output logic [CSB_WIDTH-1:0]  SPI_LE,
`endif
    output logic                  SPI_SDI,
    input  logic                  SPI_SDO
);
    localparam int DEVSEL_WIDTH = (CSB_WIDTH > 1) ? $clog2(CSB_WIDTH) : 1;
    localparam int LEN_WIDTH    = $clog2(MAX_BITS + 1);
    localparam int HALF_RAW     = (CLK_RATE + 2*BIT_RATE - 1) / (2*BIT_RATE);
    localparam int HALF_DIV     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int DIV_W        = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int HALF_W       = LEN_WIDTH + 1;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        div_q;
    logic [HALF_W-1:0]       half_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [DEVSEL_WIDTH-1:0] dev_q;
    logic                    cpha_q, lsb_q;
    logic [MAX_BITS-1:0]     tx_q, rx_q, rsp_q;
    logic                    sclk_q, sdi_q, rsp_vld_q;

    logic                    accept, tick, enter, shift_edge, sample, drive, lead;
    logic [HALF_W-1:0]       nxt_half, last_half, end_half;
    logic [LEN_WIDTH-1:0]    len_in;
    logic [MAX_BITS-1:0]     tx_in;
    logic                    csb_act;

    assign accept    = cmd.cmdValid && (state_q == S_IDLE);
    assign tick      = (div_q == DIV_W'(HALF_DIV - 1));
    assign enter     = tick && (state_q == S_SETUP || state_q == S_SHIFT);
    assign nxt_half  = (state_q == S_SETUP) ? '0 : half_q + 1'b1;
    assign end_half  = {len_q, 1'b0};
    assign last_half = end_half - 1'b1;
    // Each SCLK edge is the start of a new SHIFT half; even halves are leading edges.
    assign lead       = ~nxt_half[0];
    assign shift_edge = enter && (nxt_half != end_half);
    assign sample     = shift_edge && (lead ^ cpha_q);
    assign drive      = shift_edge && !(lead ^ cpha_q) && (nxt_half != '0) && (nxt_half != last_half);

    assign len_in = (cmd.cmdLength == '0 || cmd.cmdLength > LEN_WIDTH'(MAX_BITS))
                    ? LEN_WIDTH'(MAX_BITS) : cmd.cmdLength;
    // MSB-first words are left-justified so the shift-out bit is always the top bit.
    assign tx_in  = cmd.cmdLSBFirst ? cmd.cmdData : cmd.cmdData << (LEN_WIDTH'(MAX_BITS) - len_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_SETUP;
            S_SETUP: if (tick) state_d = S_SHIFT;
            S_SHIFT: if (tick && half_q == last_half) state_d = S_HOLD;
            S_HOLD:  if (tick) state_d = S_GAP;
            S_GAP:   if (tick) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd.cmdReady = (state_q == S_IDLE);
    assign cmd.busy     = (state_q != S_IDLE);
    assign csb_act      = (state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD);

    always_comb begin
        SPI_CSB = '1;
`ifdef SPI_MASTER_LE_EN
        SPI_LE  = '0;
`endif
        for (int i = 0; i < CSB_WIDTH; i++) begin
            if (csb_act && dev_q == DEVSEL_WIDTH'(i)) SPI_CSB[i] = 1'b0;
`ifdef SPI_MASTER_LE_EN
            if (state_q == S_GAP && dev_q == DEVSEL_WIDTH'(i)) SPI_LE[i] = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            half_q    <= '0;
            len_q     <= '0;
            dev_q     <= '0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            rsp_q     <= '0;
            sclk_q    <= 1'b0;
            sdi_q     <= 1'b0;
            rsp_vld_q <= 1'b0;
        end else begin
            rsp_vld_q <= 1'b0;
            if (state_q == S_IDLE) div_q <= '0;
            else                   div_q <= tick ? '0 : div_q + 1'b1;
            if (accept) begin
                len_q  <= len_in;
                dev_q  <= cmd.cmdDevSel;
                cpha_q <= cmd.cmdCPHA;
                lsb_q  <= cmd.cmdLSBFirst;
                tx_q   <= tx_in;
                rx_q   <= '0;
                sclk_q <= cmd.cmdCPOL;
                sdi_q  <= cmd.cmdLSBFirst ? tx_in[0] : tx_in[MAX_BITS-1];
            end
            if (enter)      half_q <= nxt_half;
            if (shift_edge) sclk_q <= ~sclk_q;
            if (sample)
                rx_q <= lsb_q ? {SPI_SDO, rx_q[MAX_BITS-1:1]} : {rx_q[MAX_BITS-2:0], SPI_SDO};
            if (drive) begin
                tx_q  <= lsb_q ? tx_q >> 1 : tx_q << 1;
                sdi_q <= lsb_q ? tx_q[1] : tx_q[MAX_BITS-2];
            end
            if (state_q == S_HOLD && tick) begin
                rsp_q     <= lsb_q ? rx_q >> (LEN_WIDTH'(MAX_BITS) - len_q) : rx_q;
                rsp_vld_q <= 1'b1;
            end
        end
    end

    assign SPI_CLK      = sclk_q;
    assign SPI_SDI      = sdi_q;
    assign cmd.rspValid = rsp_vld_q;
    assign cmd.rspData  = rsp_q;
endmodule
